// File: rtl/mi_arbiter_if.sv
// Memory-interface (mi_*) bundle for one command/data link.
// "master" drives commands and write data.
// "slave" accepts commands and returns ready, write acks and read data.
interface mi_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 7
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  rw;
    logic                  valid;
    logic                  ready;
    logic [31:0]           wdata;
    logic                  wack;
    logic [31:0]           rdata;
    logic                  rstb;

    modport master (
        output addr, len, rw, valid, wdata,
        input  ready, wack, rdata, rstb
    );

    modport slave (
        input  addr, len, rw, valid, wdata,
        output ready, wack, rdata, rstb
    );
endinterface

// File: rtl/mi_arbiter.sv
// Two-port memory-interface arbiter.
// Port 0 is the memory tester and port 1 is the video DMA.
// One port is granted per command. The grant is held until every beat of the
// burst has completed. Write acks and read strobes are steered only to the owner.
module mi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 7,
    parameter int FIXED_PRIO = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_en,
    mi_arbiter_if.slave         io_p0,
    mi_arbiter_if.slave         io_p1,
    mi_arbiter_if.master        io_m,
    output logic                o_owner,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam bit                   LP_FIXED    = (FIXED_PRIO != 0);
    localparam logic [LEN_WIDTH-1:0] LP_CNT_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LP_CNT_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_owner;
    logic                   w_owner_nxt;
    logic                   r_last;
    logic                   w_last_nxt;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [LEN_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_rw;
    logic                   w_rw_nxt;

    logic [1:0]             w_req;
    logic                   w_grant;
    logic                   w_beat;
    logic                   w_busy;
    logic                   w_in_cmd;
    logic [ADDR_WIDTH-1:0]  w_addr;

    // Requests are qualified by the enables; enables are looked at only here.
    assign w_req = {io_p1.valid & i_en[1], io_p0.valid & i_en[0]};

    // The burst direction is latched at grant time. A requester may present
    // its next command as soon as it sees ready, so we cannot rely on its rw
    // during the data phase.
    assign w_beat = r_rw ? io_m.rstb : io_m.wack;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_in_cmd = (r_state == ST_CMD);

    // Choose the winner among the active requests. On a tie, round-robin
    // picks the port that was not granted last; fixed priority picks port 1.
    always_comb begin
        w_grant = 1'b0;
        if (w_req == 2'b11) begin
            if (LP_FIXED) begin
                w_grant = 1'b1;
            end else begin
                w_grant = ~r_last;
            end
        end else if (w_req[1]) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Next-state logic: arbitrate, hand off the command, then count beats.
    // The counter holds the beats remaining minus one, so the beat seen with
    // a zero count is the last one. A full-length burst never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_rw_nxt    = r_rw;
        case (r_state)
            ST_IDLE: begin
                if (w_req != 2'b00) begin
                    w_owner_nxt = w_grant;
                    w_cnt_nxt   = w_grant ? io_p1.len : io_p0.len;
                    w_rw_nxt    = w_grant ? io_p1.rw  : io_p0.rw;
                    w_state_nxt = ST_CMD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (io_m.ready) begin
                    if (w_beat) begin
                        if (r_cnt == LP_CNT_ZERO) begin
                            w_last_nxt  = r_owner;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt   = r_cnt - LP_CNT_ONE;
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    if (r_cnt == LP_CNT_ZERO) begin
                        w_last_nxt  = r_owner;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt - LP_CNT_ONE;
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and grant registers. Port 0 wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= LP_CNT_ZERO;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rw    <= w_rw_nxt;
        end
    end

    // Command path to the controller, muxed from the current owner.
    assign w_addr      = r_owner ? io_p1.addr : io_p0.addr;
    assign io_m.addr   = w_addr;
    assign io_m.len    = r_owner ? io_p1.len   : io_p0.len;
    assign io_m.rw     = r_owner ? io_p1.rw    : io_p0.rw;
    assign io_m.wdata  = r_owner ? io_p1.wdata : io_p0.wdata;
    assign io_m.valid  = w_in_cmd;

    // Handshake and strobes go back only to the owner. Strobes outside a
    // grant are dropped.
    assign io_p0.ready = w_in_cmd & ~r_owner & io_m.ready;
    assign io_p1.ready = w_in_cmd &  r_owner & io_m.ready;
    assign io_p0.wack  = io_m.wack & ~r_owner & w_busy;
    assign io_p1.wack  = io_m.wack &  r_owner & w_busy;
    assign io_p0.rstb  = io_m.rstb & ~r_owner & w_busy;
    assign io_p1.rstb  = io_m.rstb &  r_owner & w_busy;
    assign io_p0.rdata = io_m.rdata;
    assign io_p1.rdata = io_m.rdata;

    assign o_owner = r_owner;
    assign o_busy  = w_busy;

endmodule

// File: tb/tb_mi_arbiter.sv
// Directed self-checking bench for mi_arbiter.
// It uses one round-robin instance and one fixed-priority instance.
module tb_mi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic [1:0] fp_en;
    logic       owner;
    logic       busy;
    logic       fp_owner;
    logic       fp_busy;
    int         n_checks = 0;
    int         n_errors = 0;

    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) p0 ();
    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) p1 ();
    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) m ();
    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) fp0 ();
    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) fp1 ();
    mi_arbiter_if #(.ADDR_WIDTH(32), .LEN_WIDTH(7)) fm ();

    mi_arbiter #(.ADDR_WIDTH(32), .LEN_WIDTH(7), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .io_p0(p0), .io_p1(p1), .io_m(m),
        .o_owner(owner), .o_busy(busy)
    );

    mi_arbiter #(.ADDR_WIDTH(32), .LEN_WIDTH(7), .FIXED_PRIO(1)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(fp_en),
        .io_p0(fp0), .io_p1(fp1), .io_m(fm),
        .o_owner(fp_owner), .o_busy(fp_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        p0.addr = 32'h0; p0.len = 7'd0; p0.rw = 1'b0; p0.valid = 1'b0; p0.wdata = 32'h0;
        p1.addr = 32'h0; p1.len = 7'd0; p1.rw = 1'b0; p1.valid = 1'b0; p1.wdata = 32'h0;
        m.ready = 1'b0; m.wack = 1'b0; m.rdata = 32'h0; m.rstb = 1'b0;
        fp0.addr = 32'h0; fp0.len = 7'd0; fp0.rw = 1'b0; fp0.valid = 1'b0; fp0.wdata = 32'h0;
        fp1.addr = 32'h0; fp1.len = 7'd0; fp1.rw = 1'b0; fp1.valid = 1'b0; fp1.wdata = 32'h0;
        fm.ready = 1'b0; fm.wack = 1'b0; fm.rdata = 32'h0; fm.rstb = 1'b0;
        en = 2'b11;
        fp_en = 2'b11;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Controller model for the round-robin instance: waits for m.valid,
    // accepts, then delivers nbeats strobes of the requested kind and counts
    // strobes seen per port. The owner drops its request after acceptance.
    task automatic ctrl_burst(input logic is_read, input int nbeats, input bit beat_acc,
                              input int drop_port, output int own0, output int own1,
                              output int lat, output logic cmd_owner, output bit tmo);
        own0 = 0; own1 = 0; lat = 0; tmo = 1'b0; cmd_owner = 1'b0;
        @(negedge clk);
        while (m.valid !== 1'b1 && lat < 10) begin
            lat++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (m.valid !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        cmd_owner = owner;
        m.ready = 1'b1;
        if (beat_acc) begin
            if (is_read) m.rstb = 1'b1; else m.wack = 1'b1;
        end
        #1;
        if (is_read) begin
            own0 = own0 + (p0.rstb ? 1 : 0); own1 = own1 + (p1.rstb ? 1 : 0);
        end else begin
            own0 = own0 + (p0.wack ? 1 : 0); own1 = own1 + (p1.wack ? 1 : 0);
        end
        tick();
        m.ready = 1'b0; m.rstb = 1'b0; m.wack = 1'b0;
        if (drop_port == 0) p0.valid = 1'b0; else p1.valid = 1'b0;
        for (int i = (beat_acc ? 1 : 0); i < nbeats; i++) begin
            if (is_read) m.rstb = 1'b1; else m.wack = 1'b1;
            @(negedge clk);
            if (is_read) begin
                own0 = own0 + (p0.rstb ? 1 : 0); own1 = own1 + (p1.rstb ? 1 : 0);
            end else begin
                own0 = own0 + (p0.wack ? 1 : 0); own1 = own1 + (p1.wack ? 1 : 0);
            end
            tick();
            m.rstb = 1'b0; m.wack = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        m.wack = 1'b1; m.rstb = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL reset_owner: got %b want 0", owner); end
        n_checks++; if (m.valid !== 1'b0) begin n_errors++; $display("FAIL reset_mvalid: got %b want 0", m.valid); end
        n_checks++; if ({p0.ready, p1.ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b want 00", {p0.ready, p1.ready}); end
        n_checks++; if ({p0.wack, p1.wack, p0.rstb, p1.rstb} !== 4'b0000) begin n_errors++; $display("FAIL reset_strobes: got %b want 0000", {p0.wack, p1.wack, p0.rstb, p1.rstb}); end
        tick();
        m.wack = 1'b0; m.rstb = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        int n0;
        int n1;
        n0 = 0; n1 = 0;
        p0.addr = 32'h0000_1000; p0.len = 7'd3; p0.rw = 1'b0; p0.wdata = 32'hA5A5_0001; p0.valid = 1'b1;
        p1.wdata = 32'h5A5A_0002;
        @(negedge clk);
        n_checks++; if (m.valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL sw_latency: got valid=%b busy=%b want 0 0", m.valid, busy); end
        tick();
        @(negedge clk);
        n_checks++; if (m.valid !== 1'b1) begin n_errors++; $display("FAIL sw_mvalid: got %b want 1", m.valid); end
        n_checks++; if (m.addr !== 32'h0000_1000 || m.len !== 7'd3 || m.rw !== 1'b0) begin n_errors++; $display("FAIL sw_cmd: got %h/%0d/%b want 00001000/3/0", m.addr, m.len, m.rw); end
        n_checks++; if (m.wdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL sw_wdata: got %h want a5a50001", m.wdata); end
        n_checks++; if (busy !== 1'b1 || owner !== 1'b0) begin n_errors++; $display("FAIL sw_grant: got busy=%b owner=%b want 1 0", busy, owner); end
        m.ready = 1'b1;
        #1;
        n_checks++; if ({p0.ready, p1.ready} !== 2'b10) begin n_errors++; $display("FAIL sw_ready: got %b want 10", {p0.ready, p1.ready}); end
        tick();
        m.ready = 1'b0; p0.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(negedge clk);
                n_checks++; if (busy !== 1'b1 || m.valid !== 1'b0) begin n_errors++; $display("FAIL sw_data_gap: got busy=%b valid=%b want 1 0", busy, m.valid); end
                tick();
            end
            m.wack = 1'b1;
            @(negedge clk);
            n0 = n0 + (p0.wack ? 1 : 0);
            n1 = n1 + (p1.wack ? 1 : 0);
            tick();
            m.wack = 1'b0;
        end
        n_checks++; if (n0 !== 4 || n1 !== 0) begin n_errors++; $display("FAIL sw_wack_count: got p0=%0d p1=%0d want 4 0", n0, n1); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || owner !== 1'b0) begin n_errors++; $display("FAIL sw_done: got busy=%b owner=%b want 0 0", busy, owner); end
        m.wack = 1'b1;
        #1;
        n_checks++; if (p0.wack !== 1'b0) begin n_errors++; $display("FAIL sw_idle_stray: got %b want 0", p0.wack); end
        tick();
        m.wack = 1'b0;
    endtask

    task automatic test_round_robin;
        int o0; int o1; int lat; logic co; bit tmo;
        do_reset();
        p0.addr = 32'h0000_2000; p0.len = 7'd1; p0.rw = 1'b1; p0.valid = 1'b1;
        p1.addr = 32'h0000_3000; p1.len = 7'd1; p1.rw = 1'b1; p1.valid = 1'b1;
        ctrl_burst(1'b1, 2, 1'b0, 0, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b0 || lat !== 1) begin n_errors++; $display("FAIL rr_first: got owner=%b lat=%0d tmo=%0d want 0 1 0", co, lat, tmo); end
        n_checks++; if (o0 !== 2 || o1 !== 0) begin n_errors++; $display("FAIL rr_first_rstb: got p0=%0d p1=%0d want 2 0", o0, o1); end
        p0.valid = 1'b1;
        ctrl_burst(1'b1, 2, 1'b0, 1, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b1 || lat !== 1) begin n_errors++; $display("FAIL rr_second: got owner=%b lat=%0d tmo=%0d want 1 1 0", co, lat, tmo); end
        n_checks++; if (o0 !== 0 || o1 !== 2) begin n_errors++; $display("FAIL rr_second_rstb: got p0=%0d p1=%0d want 0 2", o0, o1); end
        p1.valid = 1'b1;
        ctrl_burst(1'b1, 2, 1'b0, 0, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b0 || o0 !== 2 || o1 !== 0) begin n_errors++; $display("FAIL rr_third: got owner=%b p0=%0d p1=%0d want 0 2 0", co, o0, o1); end
        ctrl_burst(1'b1, 2, 1'b0, 1, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b1 || o1 !== 2) begin n_errors++; $display("FAIL rr_drain: got owner=%b p1=%0d want 1 2", co, o1); end
        m.rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (p0.rdata !== 32'hDEAD_BEEF || p1.rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rr_rdata: got %h %h want deadbeef", p0.rdata, p1.rdata); end
        m.rdata = 32'h0;
    endtask

    task automatic test_en_mask;
        int o0; int o1; int lat; logic co; bit tmo; int bz;
        do_reset();
        en = 2'b01;
        p1.len = 7'd0; p1.rw = 1'b0; p1.valid = 1'b1;
        p0.len = 7'd2; p0.rw = 1'b0; p0.valid = 1'b1;
        tick();
        en = 2'b00;
        ctrl_burst(1'b0, 3, 1'b0, 0, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b0 || lat !== 0) begin n_errors++; $display("FAIL en_grant: got owner=%b lat=%0d tmo=%0d want 0 0 0", co, lat, tmo); end
        n_checks++; if (o0 !== 3 || o1 !== 0) begin n_errors++; $display("FAIL en_burst: got p0=%0d p1=%0d want 3 0", o0, o1); end
        en = 2'b01;
        bz = 0;
        repeat (5) begin
            @(negedge clk);
            bz = bz + (busy ? 1 : 0);
            tick();
        end
        n_checks++; if (bz !== 0) begin n_errors++; $display("FAIL en_masked: got busy cycles=%0d want 0", bz); end
        en = 2'b11;
        ctrl_burst(1'b0, 1, 1'b0, 1, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b1 || o1 !== 1 || o0 !== 0) begin n_errors++; $display("FAIL en_unmask: got owner=%b p1=%0d p0=%0d want 1 1 0", co, o1, o0); end
    endtask

    task automatic test_long_burst;
        int o0; int o1; int lat; logic co; bit tmo;
        do_reset();
        p0.len = 7'd127; p0.rw = 1'b1; p0.valid = 1'b1;
        ctrl_burst(1'b1, 128, 1'b1, 0, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || o0 !== 128 || o1 !== 0) begin n_errors++; $display("FAIL long_rstb: got p0=%0d p1=%0d tmo=%0d want 128 0 0", o0, o1, tmo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL long_idle: got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int o0; int o1; int lat; logic co; bit tmo;
        do_reset();
        p0.len = 7'd7; p0.rw = 1'b0; p0.valid = 1'b1;
        tick();
        m.ready = 1'b1;
        tick();
        m.ready = 1'b0; p0.valid = 1'b0;
        m.wack = 1'b1;
        tick();
        tick();
        m.wack = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || m.valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_state: got busy=%b valid=%b want 0 0", busy, m.valid); end
        m.wack = 1'b1; m.rstb = 1'b1;
        #1;
        n_checks++; if ({p0.wack, p0.rstb, p1.wack, p1.rstb} !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_strobes: got %b want 0000", {p0.wack, p0.rstb, p1.wack, p1.rstb}); end
        m.wack = 1'b0; m.rstb = 1'b0;
        rst_n = 1'b1;
        tick();
        p1.len = 7'd0; p1.rw = 1'b1; p1.valid = 1'b1;
        ctrl_burst(1'b1, 1, 1'b0, 1, o0, o1, lat, co, tmo);
        n_checks++; if (tmo || co !== 1'b1 || o1 !== 1 || o0 !== 0) begin n_errors++; $display("FAIL rst_mid_fresh: got owner=%b p1=%0d p0=%0d want 1 1 0", co, o1, o0); end
    endtask

    task automatic test_fixed_prio;
        int grants; int bad; int p0w; int p1w;
        grants = 0; bad = 0; p0w = 0; p1w = 0;
        fp0.len = 7'd0; fp0.rw = 1'b0; fp0.valid = 1'b1;
        fp1.len = 7'd0; fp1.rw = 1'b0; fp1.valid = 1'b1;
        fm.ready = 1'b1; fm.wack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fm.valid === 1'b1) begin
                grants++;
                if (fp_owner !== 1'b1 || fp0.ready !== 1'b0 || fp1.ready !== 1'b1 || fp_busy !== 1'b1) bad++;
            end
            p0w = p0w + (fp0.wack ? 1 : 0);
            p1w = p1w + (fp1.wack ? 1 : 0);
            tick();
        end
        fp0.valid = 1'b0; fp1.valid = 1'b0; fm.ready = 1'b0; fm.wack = 1'b0;
        n_checks++; if (grants !== 10 || bad !== 0) begin n_errors++; $display("FAIL fp_grants: got grants=%0d bad=%0d want 10 0", grants, bad); end
        n_checks++; if (p0w !== 0 || p1w !== 10) begin n_errors++; $display("FAIL fp_wack: got p0=%0d p1=%0d want 0 10", p0w, p1w); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_en_mask();
        test_long_burst();
        test_reset_mid_burst();
        test_fixed_prio();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mi_arbiter.md
Name: mi_arbiter

Overview:
- Two-port arbiter for the memory interface (mi_*). Replaces the static dma_run mux between the memory tester (port 0) and the video DMA (port 1), upstream of the memory controller (hbus_memctrl or qpi_memctrl).
- Grants one requester per command and holds the grant until all beats of that burst have been transferred.
- Steers wack/rstb only to the owning port.

Parameters:
- ADDR_WIDTH, 32, width of mi addr on all ports.
- LEN_WIDTH, 7, width of mi len; burst beat count = len+1.
- FIXED_PRIO, 0, arbitration policy: 0 = round-robin; 1 = port 1 always wins ties.

Ports:
- clk  in  1  system clock (clk_1x domain).
- rst_n  in  1  synchronous, active-low reset.
- en  in  2  per-port request enable; bit n masks port n's valid at arbitration only.
- p0_addr / p1_addr  in  ADDR_WIDTH  requester command address.
- p0_len / p1_len  in  LEN_WIDTH  requester burst length minus one.
- p0_rw / p1_rw  in  1  1 = read, 0 = write.
- p0_valid / p1_valid  in  1  command request.
- p0_ready / p1_ready  out  1  command accepted.
- p0_wdata / p1_wdata  in  32  write data.
- p0_wack / p1_wack  out  1  write beat consumed.
- p0_rdata / p1_rdata  out  32  read data, broadcast.
- p0_rstb / p1_rstb  out  1  read beat strobe.
- m_addr  out  ADDR_WIDTH  to controller.
- m_len  out  LEN_WIDTH  to controller.
- m_rw  out  1  to controller.
- m_valid  out  1  to controller.
- m_ready  in  1  from controller.
- m_wdata  out  32  to controller.
- m_wack  in  1  from controller.
- m_rdata  in  32  from controller.
- m_rstb  in  1  from controller.
- owner  out  1  index of the currently or last granted port.
- busy  out  1  grant held (state != IDLE).

Behaviour:
- FSM states are IDLE, CMD, DATA.
- Reset values: state=IDLE, owner=0, last-granted=1 (so port 0 wins the first round-robin tie), busy=0, m_valid=0, all pN_ready/wack/rstb=0, beat counter=0.
- **IDLE**
  - req[n] = pN_valid & en[n].
  - If no request, stay in IDLE.
  - One request: grant that port.
  - Both requesting: round-robin grants the port not last granted; FIXED_PRIO=1 grants port 1.
  - On grant: register owner, load counter with len of the granted port, go to CMD next cycle. Arbitration latency is 1 cycle from valid to m_valid.
- **CMD**
  - m_valid=1.
  - m_addr/m_len/m_rw/m_wdata are combinationally muxed from the owner. Requesters hold the command stable until ready.
  - p[owner]_ready = m_ready. The other port's ready=0.
  - On m_valid & m_ready, go to DATA.
  - A beat (m_wack for write, m_rstb for read) arriving in the accept cycle is counted.
- **DATA**
  - m_valid=0.
  - Each beat matching rw decrements the counter. The beat with counter==0 is the last; go to IDLE next cycle and update last-granted=owner.
  - Beats of the wrong type are ignored and not counted.
- Steering:
  - pN_wack = m_wack & (owner==N) & busy.
  - pN_rstb = m_rstb & (owner==N) & busy.
  - In IDLE both are 0 and stray strobes are dropped.
  - m_wdata follows owner in all states.
- len=0 is a single-beat burst. len = all ones (2^LEN_WIDTH beats) must count correctly, with no counter wrap before completion.
- Deasserting en[owner] mid-grant does not abort; it only affects the next arbitration.
- Back-to-back: after IDLE is re-entered, a pending request of the other port wins under round-robin. Minimum 1 idle cycle between bursts.
- Reset asserted mid-burst: next cycle returns to reset values. Outstanding beats from the controller are dropped (controller reset in the same cycle).
- owner is held after completion. busy is high in CMD and DATA.

Test Plan:
- Single port 0 write, len=3, controller gives ready then 4 wack pulses -> m_valid high for 1+ cycles; p0_wack pulses 4×; p1_wack=0; busy falls after the 4th beat.
- Both valid same cycle after reset, round-robin -> port 0 granted first (read len=1); then port 1 granted (read len=1); then port 0 again. Each rstb is seen only by its owner.
- FIXED_PRIO=1, both valid continuously -> port 1 granted on every arbitration; port 0 starved.
- en=2'b01 with p1_valid held high -> port 1 never granted; dropping en[0] mid-burst of port 0 completes that burst normally.
- len=127 read with rstb every cycle, including in the accept cycle -> exactly 128 p0_rstb pulses; return to IDLE after the 128th.
- rst_n low during DATA after 2 of 8 beats -> next cycle busy=0, m_valid=0, all strobes 0; a fresh request is granted normally after release.
